// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard for the 32x32 integer RF.
// Define RF_WB_RR_EN for round-robin arbitration; the default is fixed priority (index 0 wins).
module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           q_rs1,
  input  logic [4:0]           q_rs2,
  output logic                 q_busy1,
  output logic                 q_busy2,
  output logic                 rf_wr,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wrdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  wb_req_t       gnt;
  logic [31:0]   busy;

`ifdef RF_WB_RR_EN
  logic [IW-1:0] rr;

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr <= '0;
    else if (gnt_vld)
      rr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
  end
`else
  // Walk from the top so the lowest valid index is the last one to win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    req_ready          = '0;
    req_ready[gnt_idx] = gnt_vld;
    gnt.rd             = req_rd[int'(gnt_idx)*5 +: 5];
    gnt.data           = req_data[int'(gnt_idx)*XLEN +: XLEN];
  end

  // rd=0 grants release the requester but never reach the RF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr     <= 1'b0;
      rf_rd     <= '0;
      rf_wrdata <= '0;
    end else begin
      rf_wr <= gnt_vld && (gnt.rd != 5'd0);
      if (gnt_vld && (gnt.rd != 5'd0)) begin
        rf_rd     <= gnt.rd;
        rf_wrdata <= gnt.data;
      end
    end
  end

  // A new issue to the same register outranks the commit of the older write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (iss_valid && (iss_rd == 5'(r)))
          busy[r] <= 1'b1;
        else if (rf_wr && (rf_rd == 5'(r)))
          busy[r] <= 1'b0;
      end
      busy[0] <= 1'b0;
    end
  end

  assign q_busy1 = busy[q_rs1];
  assign q_busy2 = busy[q_rs2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed checks for rf_wb_arbiter (NREQ=2): arbitration, latency, x0, scoreboard, async reset.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [4:0]  rd0, rd1;
  logic [31:0] d0, d1;
  logic        iss_valid;
  logic [4:0]  iss_rd, q_rs1, q_rs2;
  logic        q_busy1, q_busy2, rf_wr;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wrdata;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd({rd1, rd0}), .req_data({d1, d0}),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_wrdata(rf_wrdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g [3];
    logic [4:0] exp_w [3];
    rst = 1'b1; req_valid = '0; rd0 = '0; rd1 = '0; d0 = '0; d1 = '0;
    iss_valid = 1'b0; iss_rd = '0; q_rs1 = 5'd0; q_rs2 = 5'd0;
    #1;
    chk("rst_wr", {31'd0, rf_wr}, 32'd0);
    chk("rst_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_data", rf_wrdata, 32'd0);
    chk("rst_rdy", {30'd0, req_ready}, 32'd0);
    q_rs1 = 5'd7;
    #1;
    chk("rst_busy", {31'd0, q_busy1}, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick;

    // contention: both requesters valid for three cycles
`ifdef RF_WB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01};
    exp_w = '{5'd3, 5'd4, 5'd3};
`else
    exp_g = '{2'b01, 2'b01, 2'b01};
    exp_w = '{5'd3, 5'd3, 5'd3};
`endif
    rd0 = 5'd3; d0 = 32'hA3; rd1 = 5'd4; d1 = 32'hB4; req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("cont_rdy%0d", c), {30'd0, req_ready}, {30'd0, exp_g[c]});
      tick;
      chk($sformatf("cont_wr%0d", c), {31'd0, rf_wr}, 32'd1);
      chk($sformatf("cont_rd%0d", c), {27'd0, rf_rd}, {27'd0, exp_w[c]});
    end
    req_valid = 2'b00;
    tick;
    chk("cont_idle_wr", {31'd0, rf_wr}, 32'd0);
    chk("cont_hold_rd", {27'd0, rf_rd}, {27'd0, exp_w[2]});

    // single request, 1-cycle latency, then idle with held address/data
    rd0 = 5'd5; d0 = 32'hDEADBEEF; req_valid = 2'b01;
    #1 chk("single_rdy", {30'd0, req_ready}, 32'd1);
    tick;
    chk("single_wr", {31'd0, rf_wr}, 32'd1);
    chk("single_rd", {27'd0, rf_rd}, 32'd5);
    chk("single_data", rf_wrdata, 32'hDEADBEEF);
    req_valid = 2'b00; d0 = 32'h0;
    tick;
    chk("single_off", {31'd0, rf_wr}, 32'd0);
    chk("single_hold", rf_wrdata, 32'hDEADBEEF);

    // x0: accepted but never written, and never marked busy
    rd0 = 5'd0; d0 = 32'h1234; req_valid = 2'b01; iss_valid = 1'b1; iss_rd = 5'd0; q_rs1 = 5'd0;
    #1 chk("x0_rdy", {30'd0, req_ready}, 32'd1);
    tick;
    req_valid = 2'b00; iss_valid = 1'b0;
    chk("x0_wr", {31'd0, rf_wr}, 32'd0);
    chk("x0_busy", {31'd0, q_busy1}, 32'd0);

    // scoreboard lifecycle on r7 (r8 untouched)
    iss_valid = 1'b1; iss_rd = 5'd7; q_rs1 = 5'd7; q_rs2 = 5'd8;
    #1 chk("sb_c0", {31'd0, q_busy1}, 32'd0);
    tick; iss_valid = 1'b0;
    chk("sb_c1", {31'd0, q_busy1}, 32'd1);
    chk("sb_other", {31'd0, q_busy2}, 32'd0);
    tick; chk("sb_c2", {31'd0, q_busy1}, 32'd1);
    tick; chk("sb_c3", {31'd0, q_busy1}, 32'd1);
    rd0 = 5'd7; d0 = 32'h77; req_valid = 2'b01;
    #1 chk("sb_c4", {31'd0, q_busy1}, 32'd1);
    tick; req_valid = 2'b00;
    chk("sb_c5_wr", {31'd0, rf_wr}, 32'd1);
    chk("sb_c5_rd", {27'd0, rf_rd}, 32'd7);
    chk("sb_c5", {31'd0, q_busy1}, 32'd1);
    tick; chk("sb_c6", {31'd0, q_busy1}, 32'd0);

    // set and clear of r9 on the same edge: set wins
    iss_valid = 1'b1; iss_rd = 5'd9; q_rs2 = 5'd9;
    tick; iss_valid = 1'b0;
    rd0 = 5'd9; d0 = 32'h99; req_valid = 2'b01;
    tick; req_valid = 2'b00;
    chk("sc_wr", {31'd0, rf_wr}, 32'd1);
    chk("sc_rd", {27'd0, rf_rd}, 32'd9);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick; iss_valid = 1'b0;
    chk("sc_set_wins", {31'd0, q_busy2}, 32'd1);
    tick; chk("sc_still", {31'd0, q_busy2}, 32'd1);

    // async reset with every register busy and a write in flight
    for (int r = 1; r < 32; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
      tick;
    end
    iss_valid = 1'b0; q_rs1 = 5'd1; q_rs2 = 5'd31;
    #1;
    chk("ar_busy1_pre", {31'd0, q_busy1}, 32'd1);
    chk("ar_busy2_pre", {31'd0, q_busy2}, 32'd1);
    rd0 = 5'd12; d0 = 32'hC0FFEE; rd1 = 5'd13; d1 = 32'hBAD; req_valid = 2'b11;
    tick;
    chk("ar_wr_pre", {31'd0, rf_wr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_wr", {31'd0, rf_wr}, 32'd0);
    chk("ar_rd", {27'd0, rf_rd}, 32'd0);
    chk("ar_busy1", {31'd0, q_busy1}, 32'd0);
    chk("ar_busy2", {31'd0, q_busy2}, 32'd0);
    req_valid = 2'b00;
    #3 rst = 1'b0;
    rd1 = 5'd20; d1 = 32'h55; req_valid = 2'b10;
    #1 chk("post_rdy", {30'd0, req_ready}, 32'd2);
    tick; req_valid = 2'b00;
    chk("post_wr", {31'd0, rf_wr}, 32'd1);
    chk("post_rd", {27'd0, rf_rd}, 32'd20);
    chk("post_data", rf_wrdata, 32'h55);
    tick;
    chk("post_off", {31'd0, rf_wr}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
